// File: rtl/lin_reg_pkg.sv
// Shared definitions for the sequential linear-regression engine.
//   state_t      : engine FSM states (ST_IDLE, ST_MAC, ST_DONE)
//   DEF_*        : default parameter values
//   coef_addr_w  : coefficient address width for a given feature count
package lin_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_N_FEAT = 4;
  localparam int unsigned DEF_FEAT_W = 16;
  localparam int unsigned DEF_COEF_W = 16;
  localparam int unsigned DEF_ACC_W  = 32;

  // Address 0 is the bias, 1..n_feat are the slopes.
  function automatic int unsigned coef_addr_w(input int unsigned n_feat);
    return $clog2(n_feat + 1);
  endfunction

endpackage

// File: rtl/lin_reg_mac_unit.sv
// Combinational multiply-accumulate step: sum = acc + feat*coef (unsigned).
// Config macro: LIN_REG_SAT_EN -- when defined, sum clamps to all-ones on
// overflow; otherwise it wraps modulo 2^ACC_W.
// Ports:
//   acc  in  ACC_W   running accumulator
//   feat in  FEAT_W  feature operand
//   coef in  COEF_W  slope operand
//   sum  out ACC_W   updated accumulator
//   ovf  out 1       carry out of ACC_W bits (product bits above ACC_W included)
module lin_reg_mac_unit
  import lin_reg_pkg::*;
#(
  parameter int unsigned FEAT_W = DEF_FEAT_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [FEAT_W-1:0] feat,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int unsigned PROD_W = FEAT_W + COEF_W;
  // Wide enough to hold acc + product without losing any bit above ACC_W.
  localparam int unsigned WIDE_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  logic [PROD_W-1:0] prod;
  logic [WIDE_W-1:0] wide;

  always_comb begin
    prod = PROD_W'(feat) * PROD_W'(coef);
    wide = WIDE_W'(acc) + WIDE_W'(prod);
    ovf  = |wide[WIDE_W-1:ACC_W];
`ifdef LIN_REG_SAT_EN
    sum  = ovf ? '1 : wide[ACC_W-1:0];
`else
    sum  = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/lin_reg_seq.sv
// Sequential linear-regression engine: pred = theta0 + sum(theta[k]*x[k-1]).
// One shared MAC datapath is stepped once per feature by an IDLE->MAC->DONE FSM.
// Config macro: LIN_REG_SAT_EN (saturating accumulate, see lin_reg_mac_unit).
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   sample handshake; in_feat packs feature i at [i*FEAT_W +: FEAT_W]
//   coef_we/addr/data   coefficient write (addr 0 = bias, k = slope of feature k-1), IDLE only
//   out_valid/out_ready prediction handshake; out_pred result, out_ovf sticky overflow
module lin_reg_seq
  import lin_reg_pkg::*;
#(
  parameter int unsigned N_FEAT = DEF_N_FEAT,
  parameter int unsigned FEAT_W = DEF_FEAT_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_FEAT*FEAT_W-1:0]            in_feat,
  input  logic                                coef_we,
  input  logic [coef_addr_w(N_FEAT)-1:0]      coef_addr,
  input  logic [ACC_W-1:0]                    coef_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ACC_W-1:0]                    out_pred,
  output logic                                out_ovf
);

  localparam int unsigned ADDR_W = coef_addr_w(N_FEAT);

  state_t state, state_nxt;

  logic [ACC_W-1:0]  bias;
  logic [COEF_W-1:0] slope [N_FEAT];
  logic [FEAT_W-1:0] feat  [N_FEAT];
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] idx;
  logic              ovf;

  logic              accept;
  logic              last_step;
  logic [FEAT_W-1:0] cur_feat;
  logic [COEF_W-1:0] cur_coef;
  logic [ACC_W-1:0]  mac_sum;
  logic              mac_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE: begin
        // A pending coefficient write blocks acceptance so the sample always
        // sees a settled coefficient set.
        in_ready = !coef_we && !rst;
        accept   = in_valid && in_ready;
        if (accept) state_nxt = ST_MAC;
      end
      ST_MAC: begin
        last_step = (idx == ADDR_W'(N_FEAT - 1));
        if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand select by compare rather than direct indexing keeps the index
  // width independent of the array size.
  always_comb begin
    cur_feat = '0;
    cur_coef = '0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (idx == ADDR_W'(i)) begin
        cur_feat = feat[i];
        cur_coef = slope[i];
      end
    end
  end

  lin_reg_mac_unit #(
    .FEAT_W (FEAT_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .acc  (acc),
    .feat (cur_feat),
    .coef (cur_coef),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias <= '0;
      for (int unsigned i = 0; i < N_FEAT; i++) begin
        slope[i] <= '0;
        feat[i]  <= '0;
      end
      acc <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else begin
      // Addresses above N_FEAT match no register and are dropped.
      if (state == ST_IDLE && coef_we) begin
        if (coef_addr == '0) bias <= coef_data;
        for (int unsigned i = 0; i < N_FEAT; i++) begin
          if (coef_addr == ADDR_W'(i + 1)) slope[i] <= coef_data[COEF_W-1:0];
        end
      end
      if (accept) begin
        for (int unsigned i = 0; i < N_FEAT; i++) begin
          feat[i] <= in_feat[i*FEAT_W +: FEAT_W];
        end
        acc <= bias;
        idx <= '0;
        ovf <= 1'b0;
      end
      if (state == ST_MAC) begin
        acc <= mac_sum;
        ovf <= ovf | mac_ovf;
        idx <= last_step ? '0 : idx + ADDR_W'(1);
      end
    end
  end

  assign out_pred = acc;
  assign out_ovf  = ovf;

endmodule

// File: tb/tb_lin_reg_seq.sv
module tb_lin_reg_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: N_FEAT=2
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_feat = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic        out_valid, out_ready, out_ovf;
  logic [31:0] out_pred;

  // DUT1: N_FEAT=1
  logic        in_valid1 = 1'b0, in_ready1;
  logic [15:0] in_feat1 = '0;
  logic        coef_we1 = 1'b0;
  logic [0:0]  coef_addr1 = '0;
  logic [31:0] coef_data1 = '0;
  logic        out_valid1, out_ovf1;
  logic        out_ready1 = 1'b1;
  logic [31:0] out_pred1;

  lin_reg_seq #(.N_FEAT(2), .FEAT_W(16), .COEF_W(16), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pred(out_pred), .out_ovf(out_ovf));

  lin_reg_seq #(.N_FEAT(1), .FEAT_W(16), .COEF_W(16), .ACC_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_feat(in_feat1),
    .coef_we(coef_we1), .coef_addr(coef_addr1), .coef_data(coef_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_pred(out_pred1), .out_ovf(out_ovf1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bias plus each product, flagging any excursion past 32 bits.
  function automatic void ref_pred(input logic [63:0] bias, input logic [63:0] xs [2],
                                   input logic [63:0] ts [2], input int n,
                                   output logic [31:0] p, output logic o);
    logic [63:0] s;
    s = bias;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + xs[i] * ts[i];
      if (s > 64'hFFFF_FFFF) begin
        o = 1'b1;
`ifdef LIN_REG_SAT_EN
        s = 64'hFFFF_FFFF;
`else
        s = s & 64'hFFFF_FFFF;
`endif
      end
    end
    p = s[31:0];
  endfunction

  typedef struct {
    logic [31:0] pred;
    logic        ovf;
    int unsigned acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];

  logic [63:0] m_bias = '0;
  logic [63:0] m_th [2] = '{64'd0, 64'd0};

  // Output backpressure: forced value or random.
  logic rand_bp = 1'b0;
  logic force_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Scoreboard monitor for DUT0.
  logic prev_v = 1'b0, prev_hold = 1'b0, chk_ir = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0; prev_hold = 1'b0; chk_ir = 1'b0;
    end else begin
      if (chk_ir) begin
        chk("in_ready_after_handshake", in_ready, !coef_we);
        chk_ir = 1'b0;
      end
      if (prev_hold && sb.size() > 0) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pred", out_pred, sb[0].pred);
      end
      if (out_valid && !prev_v && sb.size() > 0)
        chk("latency", cyc - sb[0].acc_cyc, 2);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("pred", out_pred, e.pred);
          chk("ovf", out_ovf, e.ovf);
          chk_ir = 1'b1;
        end
      end
      prev_v    = out_valid && !out_ready;
      prev_hold = out_valid && !out_ready;
    end
  end

  // Scoreboard monitor for DUT1.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid1 && out_ready1) begin
      if (sb1.size() == 0) chk("unexpected_output1", out_valid1, 0);
      else begin
        e = sb1.pop_front();
        chk("pred1", out_pred1, e.pred);
        chk("ovf1", out_ovf1, e.ovf);
      end
    end
  end

  function automatic exp_t model_exp(input logic [15:0] x0, input logic [15:0] x1, input int unsigned ac);
    exp_t e;
    logic [63:0] xs [2];
    xs[0] = 64'(x0);
    xs[1] = 64'(x1);
    ref_pred(m_bias, xs, m_th, 2, e.pred, e.ovf);
    e.acc_cyc = ac;
    return e;
  endfunction

  task automatic wr0(input logic [1:0] a, input logic [31:0] d, input bit commit);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    chk("in_ready_during_write", in_ready, 0);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (commit) begin
      if (a == 2'd0) m_bias = 64'(d);
      else if (a <= 2'd2) m_th[a-1] = 64'(d[15:0]);
    end
  endtask

  task automatic send(input logic [15:0] x0, input logic [15:0] x1);
    int n;
    @(posedge clk); #1;
    in_feat = {x1, x0};
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 300);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else sb.push_back(model_exp(x0, x1, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((sb.size() != 0 || out_valid) && n < 500);
    if (n >= 500) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    int n, acc_cnt;
    int unsigned last_acc;

    // Reset state
    #2;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pred", out_pred, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    chk("in_ready1_after_reset", in_ready1, 1);

    // Test 1
    wr0(0, 32'd10000, 1); wr0(1, 32'd5000, 1); wr0(2, 32'd3, 1);
    wr0(3, 32'd77, 1);  // out of range, must not change anything
    send(16'd4, 16'd100);
    wait_idle();

    // Test 2: backpressure
    force_ready = 1'b0;
    send(16'd4, 16'd100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("in_ready_busy", in_ready, 0);
    end
    force_ready = 1'b1;
    wait_idle();

    // Test 3: overflow
    wr0(0, 32'hFFFF_FFF0, 1); wr0(1, 32'd1, 1); wr0(2, 32'd0, 1);
    send(16'h20, 16'd0);
    wait_idle();

    // Test 4a: write and sample in the same IDLE cycle
    wr0(0, 32'd10000, 1); wr0(1, 32'd5000, 1);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 2'd2; coef_data = 32'd7;
    in_feat = {16'd100, 16'd4}; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_we_collision", in_ready, 0);
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_th[1] = 64'd7;
    @(negedge clk);
    chk("accept_after_write", in_ready, 1);
    if (in_ready) sb.push_back(model_exp(16'd4, 16'd100, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Test 4b: write during MAC is ignored
    wr0(2, 32'd3, 1);
    send(16'd4, 16'd100);
    wr0(2, 32'd9, 0);
    wait_idle();
    send(16'd4, 16'd100);
    wait_idle();

    // Test 5: reset mid-MAC
    send(16'd4, 16'd100);
    #1; rst = 1'b1;
    sb.delete();
    m_bias = '0; m_th[0] = '0; m_th[1] = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_in_ready", in_ready, 0);
      chk("rst_mid_out_valid", out_valid, 0);
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
    end
    send(16'd4, 16'd100);
    wait_idle();

    // Random traffic with backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i % 6 == 0) begin
        wait_idle();
        for (int k = 0; k < 3; k++)
          wr0(2'($urandom_range(0, 3)), $urandom, 1);
        wr0(0, (i % 12 == 0) ? $urandom : $urandom_range(0, 1000), 1);
      end
      if ($urandom_range(0, 1) == 0) send(16'($urandom), 16'($urandom));
      else send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    end
    wait_idle();
    rand_bp = 1'b0;
    @(posedge clk);

    // Test 6: N_FEAT=1 back-to-back
    @(posedge clk); #1;
    coef_we1 = 1'b1; coef_addr1 = 1'b0; coef_data1 = 32'd10000;
    @(posedge clk); #1;
    coef_addr1 = 1'b1; coef_data1 = 32'd5000;
    @(posedge clk); #1;
    coef_we1 = 1'b0;
    in_feat1 = 16'd65535; in_valid1 = 1'b1;
    e.pred = 32'(64'd10000 + 64'd65535 * 64'd5000);
    e.ovf = 1'b0;
    acc_cnt = 0; last_acc = 0; n = 0;
    while (acc_cnt < 4 && n < 100) begin
      @(negedge clk); n++;
      if (in_ready1) begin
        e.acc_cyc = cyc + 1;
        sb1.push_back(e);
        if (acc_cnt > 0) chk("cadence1", cyc + 1 - last_acc, 3);
        last_acc = cyc + 1;
        acc_cnt++;
      end
    end
    if (acc_cnt < 4) chk("accept1_timeout", acc_cnt, 4);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (sb1.size() != 0 && n < 100);
    if (sb1.size() != 0) chk("drain1_timeout", sb1.size(), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
